// File: rtl/apb_arb_pkg.sv
// Shared types for the APB master arbiter: transfer state, default bus widths,
// request record layout and the round-robin pointer step.
package apb_arb_pkg;

    localparam int ARB_ADDR_W = 24;
    localparam int ARB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic [2:0]              prot;
        logic [ARB_ADDR_W-1:0]   addr;
        logic                    write;
        logic [ARB_DATA_W-1:0]   wdata;
        logic [ARB_DATA_W/8-1:0] strb;
    } apb_req_t;

    // Master served last becomes lowest priority next round.
    function automatic int rr_next(input int g, input int n);
        return (g + 1) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester at or after i_ptr wins.
// The pointer register lives in the parent.
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx
);

    logic [IW:0]   w_sum;
    logic [IW-1:0] w_cand;
    logic          w_found;

    // Walk the requesters starting at the pointer and wrapping modulo N.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_cand  = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, i_ptr} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(N)) begin
                w_sum = w_sum - (IW+1)'(N);
            end
            w_cand = w_sum[IW-1:0];
            if (!w_found && i_req[w_cand]) begin
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
                w_found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_mst_arbiter.sv
// Shares one downstream APB port between MST upstream masters, one transfer at a time.
// Optional downstream wait limit and sticky s_timeout flag: define APB_ARB_TIMEOUT_EN.
module apb_mst_arbiter
    import apb_arb_pkg::*;
#(
    parameter int MST     = 2,
    parameter int ADDR    = ARB_ADDR_W,
    parameter int DATA    = ARB_DATA_W,
    parameter int TIMEOUT = 256
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic [MST-1:0]          m_psel,
    input  logic [MST-1:0]          m_penable,
    input  logic [3*MST-1:0]        m_pprot,
    input  logic [ADDR*MST-1:0]     m_paddr,
    input  logic [MST-1:0]          m_pwrite,
    input  logic [DATA*MST-1:0]     m_pwdata,
    input  logic [(DATA/8)*MST-1:0] m_pstrb,
    output logic [DATA-1:0]         m_prdata,
    output logic [MST-1:0]          m_pslverr,
    output logic [MST-1:0]          m_pready,
    output logic                    s_psel,
    output logic                    s_penable,
    output logic                    s_pwrite,
    output logic [2:0]              s_pprot,
    output logic [ADDR-1:0]         s_paddr,
    output logic [DATA-1:0]         s_pwdata,
    output logic [DATA/8-1:0]       s_pstrb,
    input  logic [DATA-1:0]         s_prdata,
    input  logic                    s_pslverr,
    input  logic                    s_pready
`ifdef APB_ARB_TIMEOUT_EN
    ,
    output logic                    s_timeout
`endif
);

    localparam int IW = (MST > 1) ? $clog2(MST) : 1;
    localparam int SW = DATA / 8;

    arb_state_t       r_state;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_gntIdx;
    logic             r_sPsel;
    logic             r_sPenable;
    logic             r_sPwrite;
    logic [2:0]       r_sPprot;
    logic [ADDR-1:0]  r_sPaddr;
    logic [DATA-1:0]  r_sPwdata;
    logic [SW-1:0]    r_sPstrb;
    logic [DATA-1:0]  r_mPrdata;
    logic [MST-1:0]   r_mPready;
    logic [MST-1:0]   r_mPslverr;

    logic [MST-1:0]   w_req;
    logic [MST-1:0]   w_grant;
    logic [IW-1:0]    w_idx;
    logic [2:0]       w_selProt;
    logic [ADDR-1:0]  w_selAddr;
    logic             w_selWrite;
    logic [DATA-1:0]  w_selWdata;
    logic [SW-1:0]    w_selStrb;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0]    r_tmoCnt;
    logic             r_timeout;
`endif

    // Only the upstream ACCESS phase counts as a request.
    assign w_req = m_psel & m_penable;

    rr_arbiter #(.N(MST)) u_rrArbiter (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    always_comb begin
        w_selProt  = '0;
        w_selAddr  = '0;
        w_selWrite = 1'b0;
        w_selWdata = '0;
        w_selStrb  = '0;
        for (int i = 0; i < MST; i++) begin
            if (w_grant[i]) begin
                w_selProt  = m_pprot[3*i +: 3];
                w_selAddr  = m_paddr[ADDR*i +: ADDR];
                w_selWrite = m_pwrite[i];
                w_selWdata = m_pwdata[DATA*i +: DATA];
                w_selStrb  = m_pstrb[SW*i +: SW];
            end
        end
    end

    // A master that dropped psel mid-transfer still has its transfer finished
    // downstream, but its response strobes are suppressed.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_gntIdx   <= '0;
            r_sPsel    <= 1'b0;
            r_sPenable <= 1'b0;
            r_sPwrite  <= 1'b0;
            r_sPprot   <= '0;
            r_sPaddr   <= '0;
            r_sPwdata  <= '0;
            r_sPstrb   <= '0;
            r_mPrdata  <= '0;
            r_mPready  <= '0;
            r_mPslverr <= '0;
`ifdef APB_ARB_TIMEOUT_EN
            r_tmoCnt   <= '0;
            r_timeout  <= 1'b0;
`endif
        end else begin
            r_mPready  <= '0;
            r_mPslverr <= '0;
            case (r_state)
                IDLE: begin
                    if (|w_req) begin
                        r_gntIdx  <= w_idx;
                        r_sPprot  <= w_selProt;
                        r_sPaddr  <= w_selAddr;
                        r_sPwrite <= w_selWrite;
                        r_sPwdata <= w_selWdata;
                        r_sPstrb  <= w_selStrb;
                        r_sPsel   <= 1'b1;
                        r_state   <= SETUP;
                    end
                end
                SETUP: begin
                    r_sPenable <= 1'b1;
                    r_state    <= ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
                    r_tmoCnt   <= '0;
`endif
                end
                ACCESS: begin
                    if (s_pready) begin
                        r_mPrdata            <= s_prdata;
                        r_mPready[r_gntIdx]  <= m_psel[r_gntIdx];
                        r_mPslverr[r_gntIdx] <= m_psel[r_gntIdx] & s_pslverr;
                        r_sPsel              <= 1'b0;
                        r_sPenable           <= 1'b0;
                        r_state              <= RESP;
`ifdef APB_ARB_TIMEOUT_EN
                        r_timeout            <= 1'b0;
                    end else if (r_tmoCnt == CW'(TIMEOUT - 1)) begin
                        r_mPrdata            <= '0;
                        r_mPready[r_gntIdx]  <= m_psel[r_gntIdx];
                        r_mPslverr[r_gntIdx] <= m_psel[r_gntIdx];
                        r_sPsel              <= 1'b0;
                        r_sPenable           <= 1'b0;
                        r_timeout            <= 1'b1;
                        r_state              <= RESP;
                    end else begin
                        r_tmoCnt             <= r_tmoCnt + 1'b1;
`endif
                    end
                end
                RESP: begin
                    r_mPrdata <= '0;
                    r_ptr     <= IW'(rr_next(int'(r_gntIdx), MST));
                    r_state   <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign m_prdata  = r_mPrdata;
    assign m_pready  = r_mPready;
    assign m_pslverr = r_mPslverr;
    assign s_psel    = r_sPsel;
    assign s_penable = r_sPenable;
    assign s_pwrite  = r_sPwrite;
    assign s_pprot   = r_sPprot;
    assign s_paddr   = r_sPaddr;
    assign s_pwdata  = r_sPwdata;
    assign s_pstrb   = r_sPstrb;
`ifdef APB_ARB_TIMEOUT_EN
    assign s_timeout = r_timeout;
`endif

endmodule

// File: tb/tb_apb_mst_arbiter.sv
// Scoreboard bench for apb_mst_arbiter: directed transfers push expected downstream
// and upstream responses; two monitors pop and compare them as the DUT presents them.
module tb_apb_mst_arbiter;
    import apb_arb_pkg::*;

    localparam int MST = 2;
    localparam int ADDR = 24;
    localparam int DATA = 32;
    localparam int TMO = 8;

    logic              pclk = 1'b0;
    logic              preset;
    logic [MST-1:0]    m_psel, m_penable, m_pwrite;
    logic [3*MST-1:0]  m_pprot;
    logic [ADDR*MST-1:0] m_paddr;
    logic [DATA*MST-1:0] m_pwdata;
    logic [(DATA/8)*MST-1:0] m_pstrb;
    logic [DATA-1:0]   m_prdata;
    logic [MST-1:0]    m_pslverr, m_pready;
    logic              s_psel, s_penable, s_pwrite;
    logic [2:0]        s_pprot;
    logic [ADDR-1:0]   s_paddr;
    logic [DATA-1:0]   s_pwdata;
    logic [DATA/8-1:0] s_pstrb;
    logic [DATA-1:0]   s_prdata;
    logic              s_pslverr, s_pready;
`ifdef APB_ARB_TIMEOUT_EN
    logic              s_timeout;
`endif

    apb_mst_arbiter #(.MST(MST), .ADDR(ADDR), .DATA(DATA), .TIMEOUT(TMO)) dut (
        .pclk(pclk), .preset(preset),
        .m_psel(m_psel), .m_penable(m_penable), .m_pprot(m_pprot), .m_paddr(m_paddr),
        .m_pwrite(m_pwrite), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb),
        .m_prdata(m_prdata), .m_pslverr(m_pslverr), .m_pready(m_pready),
        .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite), .s_pprot(s_pprot),
        .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pstrb(s_pstrb),
        .s_prdata(s_prdata), .s_pslverr(s_pslverr), .s_pready(s_pready)
`ifdef APB_ARB_TIMEOUT_EN
        , .s_timeout(s_timeout)
`endif
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // Downstream slave model: ready after slvWait ACCESS cycles unless slvNever.
    int          slvWait = 0;
    logic [31:0] slvData = 32'h0;
    logic        slvErr = 1'b0;
    logic        slvNever = 1'b0;
    int          accCnt;

    always @(posedge pclk or posedge preset) begin
        if (preset) accCnt <= 0;
        else if (s_psel && s_penable && !s_pready) accCnt <= accCnt + 1;
        else accCnt <= 0;
    end

    assign s_pready  = s_psel && s_penable && !slvNever && (accCnt == slvWait);
    assign s_prdata  = slvData;
    assign s_pslverr = s_pready && slvErr;

    typedef struct {
        logic [MST-1:0] rdy;
        logic [MST-1:0] err;
        logic [31:0]    data;
        bit             chkData;
    } resp_t;

    resp_t    respQ[$];
    apb_req_t dsQ[$];
    int       rdyCnt[MST];
    int       errCnt[MST];
    int       penCnt = 0;
    logic     unstable = 1'b0;
    logic [ADDR-1:0] snapAddr;
    logic [DATA-1:0] snapData;

    task automatic expectResp(input int m, input logic [31:0] d, input logic e, input bit cd);
        resp_t r;
        r.rdy = '0;
        r.err = '0;
        r.rdy[m] = 1'b1;
        r.err[m] = e;
        r.data = d;
        r.chkData = cd;
        respQ.push_back(r);
    endtask

    function automatic apb_req_t mkReq(input logic [2:0] p, input logic [23:0] a, input logic w,
                                       input logic [31:0] d, input logic [3:0] s);
        apb_req_t r;
        r.prot = p; r.addr = a; r.write = w; r.wdata = d; r.strb = s;
        return r;
    endfunction

    // Upstream monitor
    always @(negedge pclk) begin
        resp_t e;
        if (!preset) begin
            for (int i = 0; i < MST; i++) begin
                if (m_pready[i]) rdyCnt[i]++;
                if (m_pslverr[i]) errCnt[i]++;
            end
            if (m_pready != '0) begin
                if (respQ.size() == 0) begin
                    check("upUnexpected", 64'(m_pready), 64'(0));
                end else begin
                    e = respQ.pop_front();
                    check("upReady", 64'(m_pready), 64'(e.rdy));
                    check("upErr", 64'(m_pslverr), 64'(e.err));
                    if (e.chkData) check("upData", 64'(m_prdata), 64'(e.data));
                end
            end
        end
    end

    // Downstream monitor
    always @(negedge pclk) begin
        apb_req_t e;
        if (!preset) begin
            if (s_psel && !s_penable) begin
                snapAddr = s_paddr;
                snapData = s_pwdata;
                unstable = 1'b0;
                penCnt = 0;
            end else if (s_psel && s_penable) begin
                penCnt++;
                if (s_paddr !== snapAddr || s_pwdata !== snapData) unstable = 1'b1;
                if (s_pready) begin
                    if (dsQ.size() == 0) begin
                        check("dsUnexpected", 64'(s_paddr), 64'(0));
                    end else begin
                        e = dsQ.pop_front();
                        check("dsAddr", 64'(s_paddr), 64'(e.addr));
                        check("dsWrite", 64'(s_pwrite), 64'(e.write));
                        check("dsWdata", 64'(s_pwdata), 64'(e.wdata));
                        check("dsStrb", 64'(s_pstrb), 64'(e.strb));
                        check("dsProt", 64'(s_pprot), 64'(e.prot));
                        check("dsStable", 64'(unstable), 64'(0));
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input int m, input apb_req_t rq);
        m_psel[m] = 1'b1;
        m_penable[m] = 1'b0;
        m_pprot[3*m +: 3] = rq.prot;
        m_paddr[ADDR*m +: ADDR] = rq.addr;
        m_pwrite[m] = rq.write;
        m_pwdata[DATA*m +: DATA] = rq.wdata;
        m_pstrb[4*m +: 4] = rq.strb;
    endtask

    task automatic masterXfer(input int m, input apb_req_t rq, input int nResp);
        int got = 0;
        int cyc = 0;
        @(posedge pclk); #1;
        applyStimulus(m, rq);
        @(posedge pclk); #1;
        m_penable[m] = 1'b1;
        while (got < nResp && cyc < 500) begin
            @(negedge pclk);
            if (m_pready[m]) got++;
            cyc++;
        end
        check($sformatf("xferDone m%0d", m), 64'(got), 64'(nResp));
        @(posedge pclk); #1;
        m_psel[m] = 1'b0;
        m_penable[m] = 1'b0;
    endtask

    task automatic checkOutput(input int m, input apb_req_t rq);
        logic [MST-1:0] oneHot;
        oneHot = '0;
        oneHot[m] = 1'b1;
        @(posedge pclk); #1;
        applyStimulus(m, rq);
        @(posedge pclk); #1;
        m_penable[m] = 1'b1;
        @(negedge pclk);
        check("T sPsel", 64'(s_psel), 64'(0));
        @(negedge pclk);
        check("T+1 sPsel", 64'(s_psel), 64'(1));
        check("T+1 sPenable", 64'(s_penable), 64'(0));
        @(negedge pclk);
        check("T+2 sPenable", 64'(s_penable), 64'(1));
        check("T+2 mPready", 64'(m_pready), 64'(0));
        @(negedge pclk);
        check("T+3 mPready", 64'(m_pready), 64'(oneHot));
        @(posedge pclk); #1;
        m_psel[m] = 1'b0;
        m_penable[m] = 1'b0;
    endtask

    task automatic resetDut();
        @(posedge pclk); #1;
        preset = 1'b1;
        repeat (2) @(posedge pclk);
        #1 preset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        apb_req_t rq, w0, w1, w2, w3, a, b;
        int cyc;
        preset = 1'b1;
        m_psel = '0; m_penable = '0; m_pwrite = '0;
        m_pprot = '0; m_paddr = '0; m_pwdata = '0; m_pstrb = '0;
        for (int i = 0; i < MST; i++) begin rdyCnt[i] = 0; errCnt[i] = 0; end
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        check("rst sPsel", 64'(s_psel), 64'(0));
        check("rst sPenable", 64'(s_penable), 64'(0));
        check("rst sPaddr", 64'(s_paddr), 64'(0));
        check("rst mPready", 64'(m_pready), 64'(0));
        check("rst mPslverr", 64'(m_pslverr), 64'(0));
        check("rst mPrdata", 64'(m_prdata), 64'(0));
        @(posedge pclk); #1 preset = 1'b0;

        $display("[TB] single read, master 0");
        slvData = 32'hDEADBEEF;
        rq = mkReq(3'd0, 24'h001234, 1'b0, 32'h0, 4'h0);
        dsQ.push_back(rq);
        expectResp(0, 32'hDEADBEEF, 1'b0, 1'b1);
        checkOutput(0, rq);

        $display("[TB] simultaneous writes after reset");
        resetDut();
        slvData = 32'h0;
        w0 = mkReq(3'd0, 24'h000010, 1'b1, 32'h0000AAAA, 4'hF);
        w1 = mkReq(3'd0, 24'h000020, 1'b1, 32'h00005555, 4'hF);
        dsQ.push_back(w0); dsQ.push_back(w1);
        expectResp(0, 32'h0, 1'b0, 1'b0); expectResp(1, 32'h0, 1'b0, 1'b0);
        fork
            masterXfer(0, w0, 1);
            masterXfer(1, w1, 1);
        join
        rq = mkReq(3'd1, 24'h000030, 1'b1, 32'h00001111, 4'h3);
        dsQ.push_back(rq);
        expectResp(0, 32'h0, 1'b0, 1'b0);
        masterXfer(0, rq, 1);
        w2 = mkReq(3'd2, 24'h000040, 1'b1, 32'h00002222, 4'hC);
        w3 = mkReq(3'd5, 24'h000050, 1'b1, 32'h00003333, 4'h1);
        dsQ.push_back(w3); dsQ.push_back(w2);
        expectResp(1, 32'h0, 1'b0, 1'b0); expectResp(0, 32'h0, 1'b0, 1'b0);
        fork
            masterXfer(0, w2, 1);
            masterXfer(1, w3, 1);
        join

        $display("[TB] master 1 read with wait states and slave error");
        slvWait = 3; slvErr = 1'b1; slvData = 32'hCAFE0001;
        for (int i = 0; i < MST; i++) begin rdyCnt[i] = 0; errCnt[i] = 0; end
        rq = mkReq(3'd3, 24'hABCDEF, 1'b0, 32'h0, 4'h0);
        dsQ.push_back(rq);
        expectResp(1, 32'hCAFE0001, 1'b1, 1'b1);
        masterXfer(1, rq, 1);
        check("waitPenableCycles", 64'(penCnt), 64'(4));
        check("m1ReadyPulses", 64'(rdyCnt[1]), 64'(1));
        check("m1ErrPulses", 64'(errCnt[1]), 64'(1));
        check("m0ReadyPulses", 64'(rdyCnt[0]), 64'(0));
        slvWait = 0; slvErr = 1'b0;

        $display("[TB] reset during ACCESS");
        slvWait = 5;
        rq = mkReq(3'd0, 24'h00BEEF, 1'b1, 32'h87654321, 4'hF);
        @(posedge pclk); #1;
        applyStimulus(0, rq);
        @(posedge pclk); #1;
        m_penable[0] = 1'b1;
        cyc = 0;
        do begin
            @(negedge pclk);
            cyc++;
        end while (!s_penable && cyc < 20);
        check("reachAccess", 64'(s_penable), 64'(1));
        #1 preset = 1'b1;
        #1;
        check("asyncRst sPsel", 64'(s_psel), 64'(0));
        check("asyncRst sPenable", 64'(s_penable), 64'(0));
        check("asyncRst sPaddr", 64'(s_paddr), 64'(0));
        check("asyncRst sPwdata", 64'(s_pwdata), 64'(0));
        check("asyncRst sPwrite", 64'(s_pwrite), 64'(0));
        m_psel = '0; m_penable = '0;
        slvWait = 0;
        @(posedge pclk); #1 preset = 1'b0;
        slvData = 32'h0BADF00D;
        rq = mkReq(3'd0, 24'h000777, 1'b0, 32'h0, 4'h0);
        dsQ.push_back(rq);
        expectResp(0, 32'h0BADF00D, 1'b0, 1'b1);
        checkOutput(0, rq);

`ifdef APB_ARB_TIMEOUT_EN
        $display("[TB] downstream timeout");
        check("tmo idle", 64'(s_timeout), 64'(0));
        slvNever = 1'b1; slvData = 32'hFFFFFFFF;
        rq = mkReq(3'd0, 24'h000099, 1'b0, 32'h0, 4'h0);
        expectResp(1, 32'h0, 1'b1, 1'b1);
        masterXfer(1, rq, 1);
        check("tmo accessCycles", 64'(penCnt), 64'(TMO));
        check("tmo flagSet", 64'(s_timeout), 64'(1));
        slvNever = 1'b0; slvData = 32'h12345678;
        rq = mkReq(3'd0, 24'h0000A0, 1'b0, 32'h0, 4'h0);
        dsQ.push_back(rq);
        expectResp(0, 32'h12345678, 1'b0, 1'b1);
        masterXfer(0, rq, 1);
        check("tmo flagCleared", 64'(s_timeout), 64'(0));
`endif

        $display("[TB] fairness under continuous master 0");
        slvData = 32'h0;
        a = mkReq(3'd0, 24'h000100, 1'b1, 32'hA0A0A0A0, 4'hF);
        b = mkReq(3'd0, 24'h000200, 1'b1, 32'hB0B0B0B0, 4'hF);
        dsQ.push_back(a); dsQ.push_back(b); dsQ.push_back(a); dsQ.push_back(a);
        expectResp(0, 32'h0, 1'b0, 1'b0); expectResp(1, 32'h0, 1'b0, 1'b0);
        expectResp(0, 32'h0, 1'b0, 1'b0); expectResp(0, 32'h0, 1'b0, 1'b0);
        fork
            masterXfer(0, a, 3);
            begin
                repeat (2) @(posedge pclk);
                masterXfer(1, b, 1);
            end
        join

        repeat (4) @(posedge pclk);
        @(negedge pclk);
        check("respQueueDrained", 64'(respQ.size()), 64'(0));
        check("dsQueueDrained", 64'(dsQ.size()), 64'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/apb_mst_arbiter.md
Name: apb_mst_arbiter

Overview:
- Shares one downstream APB slave port between MST upstream APB masters (processor and DMA by default).
- Sits in front of the peripheral APB fabric in the peripheral subsystem.
- Captures a pending upstream access, replays it downstream as a full SETUP/ACCESS transfer, and returns the response to the granted master only.
- Uses round-robin arbitration; one transfer is in flight at a time.

Parameters:
- MST, 2, number of upstream masters (2..8)
- ADDR, 24, address width
- DATA, 32, data width (multiple of 8)
- TIMEOUT, 256, downstream wait-cycle limit; used only with APB_ARB_TIMEOUT_EN

Ports:
- pclk  in  1  clock
- preset  in  1  asynchronous active-high reset
- m_psel  in  MST  per-master select
- m_penable  in  MST  per-master enable
- m_pprot  in  3*MST  flattened, master i at [3i+:3]
- m_paddr  in  ADDR*MST  flattened
- m_pwrite  in  MST  per-master write
- m_pwdata  in  DATA*MST  flattened
- m_pstrb  in  (DATA/8)*MST  flattened
- m_prdata  out  DATA  shared read data, valid when the granted master's m_pready is 1
- m_pslverr  out  MST  per-master error
- m_pready  out  MST  per-master ready
- s_psel, s_penable, s_pwrite  out  1  downstream control
- s_pprot  out  3
- s_paddr  out  ADDR
- s_pwdata  out  DATA
- s_pstrb  out  DATA/8
- s_prdata  in  DATA
- s_pslverr, s_pready  in  1

Behaviour:
- Clock and reset: single clock pclk. Reset preset is asynchronous, active-high.
- Reset values: all outputs 0; state IDLE; round-robin pointer selects master 0 as highest priority.
- Request: master i requests when m_psel[i] && m_penable[i] (upstream ACCESS phase). Upstream SETUP cycles are ignored.
- State machine, registered state:
  - IDLE: when any request is present, the rr_arbiter grant is registered, the granted master's pprot/paddr/pwrite/pwdata/pstrb are latched, then go to SETUP.
  - SETUP: s_psel=1, s_penable=0, go to ACCESS.
  - ACCESS: s_psel=1, s_penable=1. On s_pready=1, latch s_prdata and s_pslverr, go to RESP.
  - RESP: m_pready[g]=1 and m_pslverr[g]=latched error for one cycle; m_prdata=latched data. Round-robin pointer moves to g+1 mod MST. Go to IDLE.
- Minimum latency: request seen in cycle T, downstream SETUP at T+1, ACCESS at T+2, upstream pready at T+3 if the downstream slave has zero wait states.
- Outside the response cycle, m_pready and m_pslverr are 0 for every master. Non-granted masters are stalled.
- Downstream address/data outputs come from the latched values and stay stable through SETUP and ACCESS (APB compliant). They hold their last value when idle. m_prdata is 0 outside RESP.
- Simultaneous requests: the first requester at or after the pointer wins. Back-to-back requests from the same master cannot starve the others.
- Upstream master drops psel mid-transfer (protocol violation): the downstream transfer still completes and the response is discarded. No error is flagged.
- Reset asserted mid-transfer: immediate return to IDLE with all outputs 0. The downstream slave sees psel drop.
- Reads return s_prdata unmodified. No byte-lane manipulation is performed.

Optional Feature:
- Macro: APB_ARB_TIMEOUT_EN.
- With the macro: a counter clears on entering ACCESS and increments each ACCESS cycle while s_pready=0. On reaching TIMEOUT-1 with s_pready still 0:
  - move to RESP with m_pslverr[g]=1 and m_prdata=0;
  - drop s_psel and s_penable;
  - pulse the sticky flag output s_timeout (an extra 1-bit output port, reset 0, present only with the macro) until the next transfer completes normally.
- Without the macro: no counter and no s_timeout port. ACCESS waits indefinitely.

Decomposition:
- Package apb_arb_pkg: state enum typedef (IDLE, SETUP, ACCESS, RESP), default ADDR/DATA constants, and a per-master request struct {prot, addr, write, wdata, strb}.
- Sub-module rr_arbiter, parameterised by N. Inputs: req[N], ptr. Outputs: one-hot grant and its encoded index. Purely combinational; the pointer register lives in the parent.

Test Plan:
- Single read, master 0, addr 0x001234, s_prdata=0xDEADBEEF, zero-wait slave -> s_psel rises at T+1, s_penable at T+2; m_pready[0]=1 at T+3 with m_prdata=0xDEADBEEF; m_pready[1]=0 throughout.
- Simultaneous writes from masters 0 and 1 at reset, 0x10/0xAAAA and 0x20/0x5555 -> downstream order is 0x10 then 0x20. A repeat simultaneous pair is then served 1 before 0.
- Master 1 read with 3 slave wait states, s_pslverr=1 -> s_penable is held 4 cycles; m_pready[1] and m_pslverr[1] are 1 for exactly one cycle. Address and data are stable throughout.
- preset pulsed during ACCESS of a write -> all outputs go to 0 asynchronously. After release, the arbiter is in IDLE and a new request from master 0 gets SETUP one cycle after it is seen.
- With APB_ARB_TIMEOUT_EN and TIMEOUT=8, slave never ready -> after 8 ACCESS cycles: m_pslverr=1, m_prdata=0, s_timeout=1. A following normal transfer clears s_timeout.
- Master 0 requesting continuously while master 1 requests -> master 1 is granted within one transfer of its request.
